// File: rtl/pong_pkg.sv
// pong_pkg: constants and types shared by the Pong display blocks.
//   DIM          matrix dimension (rows = columns = 8)
//   LINHA_CIMA   row that holds the top paddle
//   LINHA_BAIXO  row that holds the bottom paddle
//   estado_t     scan FSM state encoding
package pong_pkg;

  localparam int DIM = 8;

  localparam logic [2:0] LINHA_CIMA  = 3'd0;
  localparam logic [2:0] LINHA_BAIXO = 3'd7;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CAPTURA = 2'd1,
    ACENDE  = 2'd2,
    APAGA   = 2'd3
  } estado_t;

endpackage

// File: rtl/padrao_linha.sv
// padrao_linha: combinational pattern of lit columns for one matrix row.
//   linha          row being generated
//   linha_bola     ball row
//   coluna_bola    ball column
//   posicao_cima   leftmost column of the top paddle
//   posicao_baixo  leftmost column of the bottom paddle
//   padrao         bit c = 1 when column c is lit (active-high)
module padrao_linha
  import pong_pkg::*;
#(
  parameter int LARGURA_RAQUETE = 2
) (
  input  logic [2:0] linha,
  input  logic [2:0] linha_bola,
  input  logic [2:0] coluna_bola,
  input  logic [2:0] posicao_cima,
  input  logic [2:0] posicao_baixo,
  output logic [7:0] padrao
);

  // 4-bit paddle ends: a paddle near the right edge extends past column 7
  // and is simply clipped, it never wraps to column 0.
  logic [3:0] fim_cima;
  logic [3:0] fim_baixo;

  assign fim_cima  = {1'b0, posicao_cima}  + 4'(LARGURA_RAQUETE - 1);
  assign fim_baixo = {1'b0, posicao_baixo} + 4'(LARGURA_RAQUETE - 1);

  always_comb begin
    padrao = '0;
    for (int c = 0; c < DIM; c++) begin
      if ((linha == LINHA_CIMA) && (4'(c) >= {1'b0, posicao_cima}) && (4'(c) <= fim_cima))
        padrao[c] = 1'b1;
      if ((linha == LINHA_BAIXO) && (4'(c) >= {1'b0, posicao_baixo}) && (4'(c) <= fim_baixo))
        padrao[c] = 1'b1;
      if ((linha == linha_bola) && (3'(c) == coluna_bola))
        padrao[c] = 1'b1;
    end
  end

endmodule

// File: rtl/driver_matriz_led.sv
// driver_matriz_led: row-multiplexed scan of the 8x8 Pong LED matrix.
//   clock, reset   free-running board clock, async active-high reset
//   habilita       1 = scan, 0 = matrix dark
//   piscar         blink the picture (end of game)
//   linha_bola, coluna_bola, posicao_cima, posicao_baixo  game display state
//   linhas         one-hot row select, active-high
//   colunas_n      column sinks, active-low
//   fim_quadro     one-cycle pulse at the end of each frame
//   db_linha       row currently being scanned
//
// state   | meaning
// OCIOSO  | matrix dark, waiting for habilita
// CAPTURA | one cycle: latch display inputs, advance blink phase
// ACENDE  | current row lit for CICLOS_POR_LINHA cycles
// APAGA   | all dark for CICLOS_APAGADO cycles, then next row / next frame
module driver_matriz_led
  import pong_pkg::*;
#(
  parameter int CICLOS_POR_LINHA = 1000,
  parameter int CICLOS_APAGADO   = 50,
  parameter int LARGURA_RAQUETE  = 2,
  parameter int QUADROS_PISCA    = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       piscar,
  input  logic [2:0] linha_bola,
  input  logic [2:0] coluna_bola,
  input  logic [2:0] posicao_cima,
  input  logic [2:0] posicao_baixo,
  output logic [7:0] linhas,
  output logic [7:0] colunas_n,
  output logic       fim_quadro,
  output logic [2:0] db_linha
);

  localparam int MAX_CICLOS = (CICLOS_POR_LINHA > CICLOS_APAGADO) ? CICLOS_POR_LINHA : CICLOS_APAGADO;
  localparam int LC = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;
  localparam int LQ = $clog2(QUADROS_PISCA + 1);

  estado_t       estado, estado_prox;
  logic [2:0]    linha, linha_prox, linha_seg, linha_padrao;
  logic [LC-1:0] cont, cont_prox;
  logic [LQ-1:0] cont_q, cont_q_prox;
  logic          fase_apagada, fase_prox;
  logic [2:0]    sh_lb, sh_cb, sh_pc, sh_pb;
  logic [2:0]    sh_lb_prox, sh_cb_prox, sh_pc_prox, sh_pb_prox;
  logic          sh_piscar, sh_piscar_prox;
  logic [2:0]    src_lb, src_cb, src_pc, src_pb;
  logic [7:0]    padrao;
  logic [7:0]    linhas_prox, colunas_prox;
  logic          fim_prox;

  // Outputs are registered from next-state values, so the pattern for the
  // row about to light is built one cycle early. Leaving CAPTURA, the
  // shadows are still being loaded, hence the live inputs are used then.
  assign linha_seg    = linha + 3'd1;
  assign linha_padrao = (estado == APAGA) ? linha_seg : LINHA_CIMA;
  assign src_lb = (estado == CAPTURA) ? linha_bola    : sh_lb;
  assign src_cb = (estado == CAPTURA) ? coluna_bola   : sh_cb;
  assign src_pc = (estado == CAPTURA) ? posicao_cima  : sh_pc;
  assign src_pb = (estado == CAPTURA) ? posicao_baixo : sh_pb;

  padrao_linha #(
    .LARGURA_RAQUETE(LARGURA_RAQUETE)
  ) u_padrao (
    .linha        (linha_padrao),
    .linha_bola   (src_lb),
    .coluna_bola  (src_cb),
    .posicao_cima (src_pc),
    .posicao_baixo(src_pb),
    .padrao       (padrao)
  );

  always_comb begin
    estado_prox    = estado;
    linha_prox     = linha;
    cont_prox      = cont;
    cont_q_prox    = cont_q;
    fase_prox      = fase_apagada;
    sh_lb_prox     = sh_lb;
    sh_cb_prox     = sh_cb;
    sh_pc_prox     = sh_pc;
    sh_pb_prox     = sh_pb;
    sh_piscar_prox = sh_piscar;
    linhas_prox    = '0;
    colunas_prox   = 8'hFF;
    fim_prox       = 1'b0;

    if (!habilita) begin
      estado_prox = OCIOSO;
      linha_prox  = '0;
      cont_prox   = '0;
      cont_q_prox = '0;
      fase_prox   = 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          estado_prox = CAPTURA;
          linha_prox  = '0;
        end
        CAPTURA: begin
          sh_lb_prox     = linha_bola;
          sh_cb_prox     = coluna_bola;
          sh_pc_prox     = posicao_cima;
          sh_pb_prox     = posicao_baixo;
          sh_piscar_prox = piscar;
          // cont_q = 0 only while not blinking, so the first blinking
          // frame always starts an on-phase.
          if (!piscar) begin
            cont_q_prox = '0;
            fase_prox   = 1'b0;
          end else if (cont_q == '0) begin
            cont_q_prox = LQ'(1);
            fase_prox   = 1'b0;
          end else if (cont_q == LQ'(QUADROS_PISCA)) begin
            cont_q_prox = LQ'(1);
            fase_prox   = ~fase_apagada;
          end else begin
            cont_q_prox = cont_q + LQ'(1);
          end
          estado_prox  = ACENDE;
          linha_prox   = '0;
          cont_prox    = LC'(CICLOS_POR_LINHA - 1);
          linhas_prox  = 8'h01;
          colunas_prox = (piscar && fase_prox) ? 8'hFF : ~padrao;
        end
        ACENDE: begin
          if (cont == '0) begin
            estado_prox = APAGA;
            cont_prox   = LC'(CICLOS_APAGADO - 1);
          end else begin
            cont_prox    = cont - LC'(1);
            linhas_prox  = linhas;
            colunas_prox = colunas_n;
          end
        end
        APAGA: begin
          if (cont == '0) begin
            if (linha == LINHA_BAIXO) begin
              estado_prox = CAPTURA;
              linha_prox  = '0;
              fim_prox    = 1'b1;
            end else begin
              estado_prox  = ACENDE;
              linha_prox   = linha_seg;
              cont_prox    = LC'(CICLOS_POR_LINHA - 1);
              linhas_prox  = 8'h01 << linha_seg;
              colunas_prox = (sh_piscar && fase_apagada) ? 8'hFF : ~padrao;
            end
          end else begin
            cont_prox = cont - LC'(1);
          end
        end
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      linha        <= '0;
      cont         <= '0;
      cont_q       <= '0;
      fase_apagada <= 1'b0;
      sh_lb        <= '0;
      sh_cb        <= '0;
      sh_pc        <= '0;
      sh_pb        <= '0;
      sh_piscar    <= 1'b0;
      linhas       <= '0;
      colunas_n    <= 8'hFF;
      fim_quadro   <= 1'b0;
    end else begin
      estado       <= estado_prox;
      linha        <= linha_prox;
      cont         <= cont_prox;
      cont_q       <= cont_q_prox;
      fase_apagada <= fase_prox;
      sh_lb        <= sh_lb_prox;
      sh_cb        <= sh_cb_prox;
      sh_pc        <= sh_pc_prox;
      sh_pb        <= sh_pb_prox;
      sh_piscar    <= sh_piscar_prox;
      linhas       <= linhas_prox;
      colunas_n    <= colunas_prox;
      fim_quadro   <= fim_prox;
    end
  end

  assign db_linha = linha;

endmodule

// File: tb/tb_driver_matriz_led.sv
// tb_driver_matriz_led: scoreboard bench for driver_matriz_led with short
// timing (4 lit + 2 blank cycles per row, blink every 2 frames, frame = 49).
module tb_driver_matriz_led;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic       piscar = 1'b0;
  logic [2:0] linha_bola = '0;
  logic [2:0] coluna_bola = '0;
  logic [2:0] posicao_cima = '0;
  logic [2:0] posicao_baixo = '0;
  logic [7:0] linhas;
  logic [7:0] colunas_n;
  logic       fim_quadro;
  logic [2:0] db_linha;

  driver_matriz_led #(
    .CICLOS_POR_LINHA(4),
    .CICLOS_APAGADO  (2),
    .LARGURA_RAQUETE (2),
    .QUADROS_PISCA   (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .habilita     (habilita),
    .piscar       (piscar),
    .linha_bola   (linha_bola),
    .coluna_bola  (coluna_bola),
    .posicao_cima (posicao_cima),
    .posicao_baixo(posicao_baixo),
    .linhas       (linhas),
    .colunas_n    (colunas_n),
    .fim_quadro   (fim_quadro),
    .db_linha     (db_linha)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] row;
    logic [7:0] col;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   n_chk = 0;
  int   n_ok = 0;
  int   viol = 0;
  int   rows_seen = 0;
  logic [7:0] linhas_ant = '0;

  // Monitor: records each newly lit row and flags unsafe row sequences.
  always @(negedge clock) begin
    ent_t o;
    if ($countones(linhas) > 1) viol++;
    if (linhas != 8'h00 && linhas_ant != 8'h00 && linhas != linhas_ant) viol++;
    if (linhas != 8'h00 && linhas != linhas_ant) begin
      o.row = '0;
      for (int i = 0; i < 8; i++) if (linhas[i]) o.row = 3'(i);
      o.col = colunas_n;
      obs_q.push_back(o);
      rows_seen++;
    end
    linhas_ant = linhas;
  end

  function automatic logic [7:0] exp_cols(input int r, input int lb, input int cb,
                                          input int pc, input int pb);
    logic [7:0] m;
    m = 8'h00;
    for (int k = 0; k < 2; k++) begin
      if (r == 0 && pc + k < 8) m[pc + k] = 1'b1;
      if (r == 7 && pb + k < 8) m[pb + k] = 1'b1;
    end
    if (r == lb) m[cb] = 1'b1;
    return ~m;
  endfunction

  task automatic set_inputs(input int lb, input int cb, input int pc, input int pb);
    linha_bola    = 3'(lb);
    coluna_bola   = 3'(cb);
    posicao_cima  = 3'(pc);
    posicao_baixo = 3'(pb);
  endtask

  task automatic push_frame(input int lb, input int cb, input int pc, input int pb,
                            input bit dark);
    ent_t e;
    for (int r = 0; r < 8; r++) begin
      e.row = 3'(r);
      e.col = dark ? 8'hFF : exp_cols(r, lb, cb, pc, pb);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_obs(input int n, input string nm);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (obs_q.size() < n) begin
      n_chk++;
      $display("FAIL %s timeout: rows seen %0d, needed %0d", nm, obs_q.size(), n);
    end
  endtask

  // Leaves the bench at the negedge inside CAPTURA with empty queues, so
  // inputs set right after are latched for the following frame.
  task automatic sync_frame(input string nm);
    int t;
    t = 0;
    @(negedge clock);
    while (fim_quadro !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (fim_quadro !== 1'b1) begin
      n_chk++;
      $display("FAIL %s frame sync timeout: fim_quadro %b, expected 1", nm, fim_quadro);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_chk++; if (linhas !== 8'h00) $display("FAIL reset linhas: got %h, expected 00", linhas); else n_ok++;
    n_chk++; if (colunas_n !== 8'hFF) $display("FAIL reset colunas_n: got %h, expected FF", colunas_n); else n_ok++;
    n_chk++; if (fim_quadro !== 1'b0) $display("FAIL reset fim_quadro: got %b, expected 0", fim_quadro); else n_ok++;
    n_chk++; if (db_linha !== 3'd0) $display("FAIL reset db_linha: got %0d, expected 0", db_linha); else n_ok++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_scan;
    ent_t e, o;
    int   per;
    set_inputs(3, 5, 2, 6);
    push_frame(3, 5, 2, 6, 1'b0);
    habilita = 1'b1;
    @(posedge clock); #1;
    n_chk++; if (linhas !== 8'h00) $display("FAIL latency edge1 linhas: got %h, expected 00", linhas); else n_ok++;
    @(posedge clock); #1;
    n_chk++; if (linhas !== 8'h01 || colunas_n !== 8'hF3)
      $display("FAIL latency edge2: got linhas %h colunas_n %h, expected 01 F3", linhas, colunas_n);
    else n_ok++;
    wait_obs(8, "scan");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL scan row %0d: no row captured, expected %h", e.row, e.col);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL scan row: got r%0d %h, expected r%0d %h", o.row, o.col, e.row, e.col);
        else n_ok++;
      end
    end
    sync_frame("period");
    per = 0;
    @(negedge clock); per++;
    while (fim_quadro !== 1'b1 && per < 200) begin
      @(negedge clock);
      per++;
    end
    n_chk++; if (per != 49) $display("FAIL frame period: got %0d, expected 49", per); else n_ok++;
  endtask

  task automatic test_clip;
    ent_t e, o;
    sync_frame("clip");
    set_inputs(3, 5, 7, 6);
    push_frame(3, 5, 7, 6, 1'b0);
    wait_obs(8, "clip");
    sync_frame("clip2");
    set_inputs(0, 7, 7, 6);
    push_frame(0, 7, 7, 6, 1'b0);
    wait_obs(8, "clip2");
    n_chk++;
    if (obs_q.size() == 0 || obs_q[0].col !== 8'h7F) $display("FAIL clip overlap row0: expected 7F");
    else n_ok++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL clip row %0d: no row captured, expected %h", e.row, e.col);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL clip row: got r%0d %h, expected r%0d %h", o.row, o.col, e.row, e.col);
        else n_ok++;
      end
    end
  endtask

  task automatic test_midframe;
    ent_t e, o;
    sync_frame("mid");
    set_inputs(3, 5, 2, 6);
    push_frame(3, 5, 2, 6, 1'b0);
    wait_obs(3, "mid");
    set_inputs(4, 1, 2, 6);
    wait_obs(8, "mid");
    sync_frame("mid2");
    push_frame(4, 1, 2, 6, 1'b0);
    // first frame entries were consumed by sync; rebuild from stored rows
    wait_obs(8, "mid2");
    n_chk++;
    if (obs_q.size() < 5 || obs_q[4].col !== 8'hFD) $display("FAIL mid next frame row4: expected FD");
    else n_ok++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL mid row %0d: no row captured, expected %h", e.row, e.col);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL mid row: got r%0d %h, expected r%0d %h", o.row, o.col, e.row, e.col);
        else n_ok++;
      end
    end
  endtask

  task automatic test_no_tear;
    ent_t e, o;
    sync_frame("tear");
    set_inputs(3, 5, 2, 6);
    push_frame(3, 5, 2, 6, 1'b0);
    wait_obs(3, "tear");
    set_inputs(4, 1, 0, 0);
    wait_obs(8, "tear");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL tear row %0d: no row captured, expected %h", e.row, e.col);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL tear row: got r%0d %h, expected r%0d %h", o.row, o.col, e.row, e.col);
        else n_ok++;
      end
    end
  endtask

  task automatic test_blink;
    ent_t e, o;
    sync_frame("blink");
    set_inputs(3, 5, 2, 6);
    piscar = 1'b1;
    push_frame(3, 5, 2, 6, 1'b0);
    push_frame(3, 5, 2, 6, 1'b0);
    push_frame(3, 5, 2, 6, 1'b1);
    push_frame(3, 5, 2, 6, 1'b1);
    push_frame(3, 5, 2, 6, 1'b0);
    wait_obs(40, "blink");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL blink row %0d: no row captured, expected %h", e.row, e.col);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL blink row: got r%0d %h, expected r%0d %h", o.row, o.col, e.row, e.col);
        else n_ok++;
      end
    end
    // after on, on, off, off, on the next frame would be on; stop after
    // two more so piscar=0 lands where an off-frame would otherwise follow
    sync_frame("blink2");
    push_frame(3, 5, 2, 6, 1'b0);
    wait_obs(8, "blink2");
    sync_frame("blink3");
    piscar = 1'b0;
    push_frame(3, 5, 2, 6, 1'b0);
    wait_obs(8, "blink3");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL unblink row %0d: no row captured, expected %h", e.row, e.col);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL unblink row: got r%0d %h, expected r%0d %h", o.row, o.col, e.row, e.col);
        else n_ok++;
      end
    end
  endtask

  task automatic test_disable;
    int t;
    sync_frame("dis");
    t = 0;
    while (!(db_linha == 3'd4 && linhas != 8'h00) && t < 200) begin
      @(negedge clock);
      t++;
    end
    n_chk++; if (linhas !== 8'h10) $display("FAIL disable reach row4: got linhas %h, expected 10", linhas); else n_ok++;
    habilita = 1'b0;
    @(posedge clock); #1;
    n_chk++; if (linhas !== 8'h00 || colunas_n !== 8'hFF)
      $display("FAIL disable dark: got linhas %h colunas_n %h, expected 00 FF", linhas, colunas_n);
    else n_ok++;
    @(negedge clock);
    habilita = 1'b1;
    @(posedge clock); #1;
    n_chk++; if (linhas !== 8'h00) $display("FAIL reenable edge1: got linhas %h, expected 00", linhas); else n_ok++;
    @(posedge clock); #1;
    n_chk++; if (linhas !== 8'h01 || db_linha !== 3'd0)
      $display("FAIL reenable edge2: got linhas %h row %0d, expected 01 row 0", linhas, db_linha);
    else n_ok++;
  endtask

  task automatic test_async_reset;
    int t;
    sync_frame("areset");
    t = 0;
    while (!(db_linha == 3'd2 && linhas != 8'h00) && t < 200) begin
      @(negedge clock);
      t++;
    end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (linhas !== 8'h00) $display("FAIL async reset linhas: got %h, expected 00", linhas); else n_ok++;
    n_chk++; if (colunas_n !== 8'hFF) $display("FAIL async reset colunas_n: got %h, expected FF", colunas_n); else n_ok++;
    n_chk++; if (db_linha !== 3'd0) $display("FAIL async reset db_linha: got %0d, expected 0", db_linha); else n_ok++;
    n_chk++; if (fim_quadro !== 1'b0) $display("FAIL async reset fim_quadro: got %b, expected 0", fim_quadro); else n_ok++;
    @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
  endtask

  task automatic test_safety;
    n_chk++; if (viol !== 0) $display("FAIL row safety: got %0d violations, expected 0", viol); else n_ok++;
    n_chk++; if (rows_seen < 100) $display("FAIL rows scanned: got %0d, expected at least 100", rows_seen); else n_ok++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_clip();
    test_no_tear();
    test_midframe();
    test_blink();
    test_disable();
    test_async_reset();
    test_safety();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
